// File: rtl/ecc_scrub_pkg.sv
// ---------------------------------------------------------------------------
// ecc_scrub_pkg
// Shared definitions for the patrol-scrub controller:
//   - default widths for word addresses, error counters and the inter-read
//     interval
//   - the controller state encoding
// No ports; imported by the interface, the top and the counter sub-module.
// ---------------------------------------------------------------------------
package ecc_scrub_pkg;

    localparam int ADDR_W_DEF = 28;  // 64-bit word address width
    localparam int CNT_W_DEF  = 16;  // error counter width
    localparam int IVL_W_DEF  = 16;  // idle-interval width

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // disabled, cursor parked on cfg_base
        ST_WAIT = 3'd1,   // idle countdown between scrub reads
        ST_REQ  = 3'd2,   // scrub read offered to the arbiter
        ST_RSP  = 3'd3,   // waiting for the decoder result
        ST_WB   = 3'd4,   // corrected word offered for write-back
        ST_NEXT = 3'd5    // advance / wrap the cursor
    } scrub_state_e;

    // Largest value representable in a w-bit counter (saturation point).
    function automatic logic [63:0] all_ones(input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < w; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ---------------------------------------------------------------------------
// ecc_scrub_ctrl_if
// Bus bundle between the scrub controller and the memory side (DRAM
// controller arbiter plus the SECDED decoder result path).
//   rd_req_valid/ready/addr          scrub read request channel
//   rd_rsp_valid/data/single/double  decoder result channel
//   wr_req_valid/ready/addr/data     corrected write-back channel
// Modports:
//   master - the scrub controller
//   slave  - the memory side (arbiter + decoder)
// ---------------------------------------------------------------------------
interface ecc_scrub_ctrl_if
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;

    logic              rd_rsp_valid;
    logic [63:0]       rd_rsp_data;
    logic              rd_rsp_single_err;
    logic              rd_rsp_double_err;

    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [63:0]       wr_req_data;

    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_data, rd_rsp_single_err, rd_rsp_double_err,
        output wr_req_valid, wr_req_addr, wr_req_data,
        input  wr_req_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_data, rd_rsp_single_err, rd_rsp_double_err,
        input  wr_req_valid, wr_req_addr, wr_req_data,
        output wr_req_ready
    );

endinterface

// File: rtl/ecc_sat_cnt.sv
// ---------------------------------------------------------------------------
// ecc_sat_cnt
// Saturating up-counter used for the correctable / uncorrectable error
// tallies. Sticks at all-ones; only reset clears it.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   inc    in   count one event this cycle
//   count  out  W-bit saturating count
// ---------------------------------------------------------------------------
module ecc_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// ecc_scrub_ctrl
// Patrol-scrub and error-recovery controller for the 64+8 SECDED DRAM read
// path. Walks the word region [cfg_base, cfg_limit], one read at a time,
// with cfg_interval idle cycles between reads. Correctable results are
// written back so the memory controller re-encodes the check bits;
// uncorrectable results are counted, their address logged and an interrupt
// pulse raised.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cfg_en             scrub enable (level)
//   cfg_base/limit     inclusive word-address region
//   cfg_interval       idle cycles between scrub reads
//   bus (master)       read request, decoder response, write-back channels
//   ce_count/ue_count  saturating correctable / uncorrectable counts
//   ue_addr            address of the most recent uncorrectable error
//   ue_irq             one-cycle pulse per uncorrectable error
//   pass_done          one-cycle pulse when the cursor wraps to cfg_base
// ---------------------------------------------------------------------------
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int IVL_W  = IVL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_limit,
    input  logic [IVL_W-1:0]  cfg_interval,

    ecc_scrub_ctrl_if.master  bus,

    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count,
    output logic [ADDR_W-1:0] ue_addr,
    output logic              ue_irq,
    output logic              pass_done
);

    // Index into the error-counter bank.
    localparam int CE_IDX = 0;
    localparam int UE_IDX = 1;

    scrub_state_e      state_reg,     state_next;
    logic [ADDR_W-1:0] cursor_reg,    cursor_next;
    logic [IVL_W-1:0]  countdown_reg, countdown_next;
    logic [ADDR_W-1:0] wb_addr_reg,   wb_addr_next;
    logic [63:0]       wb_data_reg,   wb_data_next;
    logic [ADDR_W-1:0] ue_addr_reg,   ue_addr_next;
    logic              ue_irq_reg,    ue_irq_next;
    logic              pass_done_reg, pass_done_next;

    logic [1:0]        err_inc;
    logic [CNT_W-1:0]  err_count [2];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cursor_reg    <= '0;
            countdown_reg <= '0;
            wb_addr_reg   <= '0;
            wb_data_reg   <= '0;
            ue_addr_reg   <= '0;
            ue_irq_reg    <= 1'b0;
            pass_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cursor_reg    <= cursor_next;
            countdown_reg <= countdown_next;
            wb_addr_reg   <= wb_addr_next;
            wb_data_reg   <= wb_data_next;
            ue_addr_reg   <= ue_addr_next;
            ue_irq_reg    <= ue_irq_next;
            pass_done_reg <= pass_done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cursor_next    = cursor_reg;
        countdown_next = countdown_reg;
        wb_addr_next   = wb_addr_reg;
        wb_data_next   = wb_data_reg;
        ue_addr_next   = ue_addr_reg;
        ue_irq_next    = 1'b0;
        pass_done_next = 1'b0;
        err_inc        = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                // Parked on the region start so re-enabling always begins a
                // fresh pass.
                cursor_next = cfg_base;
                if (cfg_en) begin
                    state_next     = ST_WAIT;
                    countdown_next = cfg_interval;
                end
            end

            ST_WAIT: begin
                // Nothing is in flight here, so disable takes effect at once.
                if (!cfg_en) begin
                    state_next = ST_IDLE;
                end else if (countdown_reg == '0) begin
                    state_next = ST_REQ;
                end else begin
                    countdown_next = countdown_reg - 1'b1;
                end
            end

            ST_REQ: begin
                // Once offered, the read stays up until accepted even if
                // cfg_en drops.
                if (bus.rd_req_ready) begin
                    state_next = ST_RSP;
                end
            end

            ST_RSP: begin
                if (bus.rd_rsp_valid) begin
                    // Uncorrectable wins over correctable: the corrected data
                    // cannot be trusted, so nothing is written back.
                    if (bus.rd_rsp_double_err) begin
                        err_inc[UE_IDX] = 1'b1;
                        ue_irq_next     = 1'b1;
                        ue_addr_next    = cursor_reg;
                        state_next      = ST_NEXT;
                    end else if (bus.rd_rsp_single_err) begin
                        err_inc[CE_IDX] = 1'b1;
                        wb_addr_next    = cursor_reg;
                        wb_data_next    = bus.rd_rsp_data;
                        state_next      = ST_WB;
                    end else begin
                        state_next = ST_NEXT;
                    end
                end
            end

            ST_WB: begin
                if (bus.wr_req_ready) begin
                    state_next = ST_NEXT;
                end
            end

            ST_NEXT: begin
                // The >= test also covers base > limit: the cursor sits on
                // base, compares past the limit and wraps after every read.
                if (cursor_reg >= cfg_limit) begin
                    cursor_next    = cfg_base;
                    pass_done_next = 1'b1;
                end else begin
                    cursor_next = cursor_reg + 1'b1;
                end
                if (cfg_en) begin
                    state_next     = ST_WAIT;
                    countdown_next = cfg_interval;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Error counters: one saturating counter per error class
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
            ecc_sat_cnt #(
                .W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (err_inc[gi]),
                .count (err_count[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs: valids decode straight from the state register, payloads come
    // from registers that only move on handshake, so both stay stable while
    // the arbiter stalls.
    // -----------------------------------------------------------------------
    assign bus.rd_req_valid = (state_reg == ST_REQ);
    assign bus.rd_req_addr  = cursor_reg;
    assign bus.wr_req_valid = (state_reg == ST_WB);
    assign bus.wr_req_addr  = wb_addr_reg;
    assign bus.wr_req_data  = wb_data_reg;

    assign ce_count  = err_count[CE_IDX];
    assign ue_count  = err_count[UE_IDX];
    assign ue_addr   = ue_addr_reg;
    assign ue_irq    = ue_irq_reg;
    assign pass_done = pass_done_reg;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ecc_scrub_ctrl
// Plays the arbiter and decoder for ecc_scrub_ctrl. A reference model of the
// scrub walk (cursor, wrap count, saturating tallies, last UE address) runs
// alongside and predicts every request address, write-back and counter value.
// ---------------------------------------------------------------------------
module tb_ecc_scrub_ctrl;

    localparam int ADDR_W = 28;
    localparam int CNT_W  = 2;
    localparam int IVL_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_en = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W-1:0] cfg_limit = '0;
    logic [IVL_W-1:0]  cfg_interval = '0;
    logic [CNT_W-1:0]  ce_count;
    logic [CNT_W-1:0]  ue_count;
    logic [ADDR_W-1:0] ue_addr;
    logic              ue_irq;
    logic              pass_done;

    ecc_scrub_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ecc_scrub_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .IVL_W  (IVL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .cfg_base     (cfg_base),
        .cfg_limit    (cfg_limit),
        .cfg_interval (cfg_interval),
        .bus          (bus),
        .ce_count     (ce_count),
        .ue_count     (ue_count),
        .ue_addr      (ue_addr),
        .ue_irq       (ue_irq),
        .pass_done    (pass_done)
    );

    always #5 clk = ~clk;

    // Free-running cycle count and pulse monitors.
    int cyc      = 0;
    int irq_cnt  = 0;
    int pass_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ue_irq)    irq_cnt++;
        if (pass_done) pass_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ADDR_W-1:0] m_base, m_limit, m_cur, m_ue_addr;
    int ce_exp = 0, ue_exp = 0, irq_exp = 0, pass_exp = 0;
    int last_req_cyc = 0;
    bit prev_simple = 0;

    function automatic void model_advance();
        if (m_cur >= m_limit) begin
            m_cur = m_base;
            pass_exp++;
        end else begin
            m_cur = m_cur + 1'b1;
        end
    endfunction

    task automatic set_region(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                              input int ivl);
        cfg_base     = b;
        cfg_limit    = l;
        cfg_interval = IVL_W'(ivl);
        m_base       = b;
        m_limit      = l;
        m_cur        = b;
        prev_simple  = 0;
    endtask

    // One scrub word. kind: 0 clean, 1 correctable, 2 uncorrectable.
    task automatic do_word(input int stall, input int lat, input int kind,
                           input logic [63:0] data, input int wr_stall, input bit drop_en);
        int n;
        bit sgl;
        n = 0;
        while (!bus.rd_req_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rd_req_valid) begin
            check_eq("req_timeout", 64'd0, 64'd1);
            return;
        end
        check_eq("rd_addr", bus.rd_req_addr, m_cur);
        check_eq("pass_cnt", pass_cnt, pass_exp);
        if (prev_simple) check_eq("period", cyc - last_req_cyc, 5 + int'(cfg_interval));
        last_req_cyc = cyc;

        repeat (stall) begin
            @(negedge clk);
            check_eq("rd_hold_valid", bus.rd_req_valid, 1);
            check_eq("rd_hold_addr", bus.rd_req_addr, m_cur);
        end
        bus.rd_req_ready = 1'b1;
        @(negedge clk);
        bus.rd_req_ready = 1'b0;
        check_eq("rd_single_outstanding", bus.rd_req_valid, 0);
        if (drop_en) cfg_en = 1'b0;

        repeat (lat) @(negedge clk);
        sgl = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
        bus.rd_rsp_valid      = 1'b1;
        bus.rd_rsp_data       = data;
        bus.rd_rsp_single_err = sgl;
        bus.rd_rsp_double_err = (kind == 2);
        @(negedge clk);
        bus.rd_rsp_valid      = 1'b0;
        bus.rd_rsp_single_err = 1'b0;
        bus.rd_rsp_double_err = 1'b0;
        bus.rd_rsp_data       = {$urandom, $urandom};

        if (kind == 2) begin
            if (ue_exp < CMAX) ue_exp++;
            irq_exp++;
            m_ue_addr = m_cur;
        end
        if (kind == 1 && ce_exp < CMAX) ce_exp++;
        check_eq("ce_count", ce_count, ce_exp);
        check_eq("ue_count", ue_count, ue_exp);
        check_eq("ue_irq", ue_irq, kind == 2);
        if (kind == 2) check_eq("ue_addr", ue_addr, m_ue_addr);
        check_eq("wr_valid", bus.wr_req_valid, kind == 1);

        if (kind == 1) begin
            check_eq("wr_addr", bus.wr_req_addr, m_cur);
            check_eq("wr_data", bus.wr_req_data, data);
            repeat (wr_stall) begin
                @(negedge clk);
                check_eq("wr_hold_valid", bus.wr_req_valid, 1);
                check_eq("wr_hold_addr", bus.wr_req_addr, m_cur);
                check_eq("wr_hold_data", bus.wr_req_data, data);
            end
            bus.wr_req_ready = 1'b1;
            @(negedge clk);
            bus.wr_req_ready = 1'b0;
            check_eq("wr_drop", bus.wr_req_valid, 0);
        end

        $display("word addr=%07h kind=%0d data=%016h stall=%0d lat=%0d ce=%0d ue=%0d",
                 m_cur, kind, data, stall, lat, ce_count, ue_count);
        model_advance();
        if (drop_en) m_cur = m_base;
        prev_simple = (stall == 0 && lat == 1 && kind == 0 && !drop_en);
    endtask

    task automatic idle_check(input int ncyc);
        int seen;
        seen = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (bus.rd_req_valid || bus.wr_req_valid) seen++;
        end
        check_eq("idle_no_req", seen, 0);
        check_eq("idle_pass_cnt", pass_cnt, pass_exp);
        check_eq("idle_cursor", bus.rd_req_addr, m_base);
    endtask

    initial begin
        int n;
        int kind;
        bus.rd_req_ready      = 1'b0;
        bus.rd_rsp_valid      = 1'b0;
        bus.rd_rsp_data       = '0;
        bus.rd_rsp_single_err = 1'b0;
        bus.rd_rsp_double_err = 1'b0;
        bus.wr_req_ready      = 1'b0;

        // ---- reset state ----
        set_region(28'h10, 28'h13, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_rd_valid", bus.rd_req_valid, 0);
        check_eq("rst_rd_addr", bus.rd_req_addr, 0);
        check_eq("rst_wr_valid", bus.wr_req_valid, 0);
        check_eq("rst_wr_addr", bus.wr_req_addr, 0);
        check_eq("rst_ce", ce_count, 0);
        check_eq("rst_ue", ue_count, 0);
        check_eq("rst_ue_addr", ue_addr, 0);
        check_eq("rst_irq", ue_irq, 0);
        check_eq("rst_pass", pass_done, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_loads_base", bus.rd_req_addr, 28'h10);

        // ---- stray response while idle must be ignored ----
        bus.rd_rsp_valid      = 1'b1;
        bus.rd_rsp_double_err = 1'b1;
        bus.rd_rsp_single_err = 1'b1;
        @(negedge clk);
        bus.rd_rsp_valid      = 1'b0;
        bus.rd_rsp_double_err = 1'b0;
        bus.rd_rsp_single_err = 1'b0;
        @(negedge clk);
        check_eq("stray_ue", ue_count, 0);
        check_eq("stray_ce", ce_count, 0);
        check_eq("stray_irq", irq_cnt, 0);

        // ---- directed pass over 0x10..0x13 ----
        cfg_en = 1'b1;
        do_word(0, 1, 0, 64'h1111, 0, 0);                   // 0x10 clean
        do_word(0, 1, 2, 64'h2222, 0, 0);                   // 0x11 double
        do_word(0, 1, 1, 64'hDEADBEEF_01234567, 2, 0);      // 0x12 single
        do_word(0, 1, 0, 64'h4444, 0, 0);                   // 0x13 clean
        do_word(0, 1, 0, 64'h5555, 0, 0);                   // 0x10 after wrap
        do_word(0, 1, 0, 64'h6666, 0, 0);                   // 0x11
        // ready low 10 cycles, cfg_en dropped during RSP
        do_word(10, 1, 0, 64'h7777, 0, 1);
        idle_check(20);

        // ---- base above limit, saturating correctable count ----
        set_region(28'h20, 28'h1F, 2);
        cfg_en = 1'b1;
        do_word(0, 1, 0, {$urandom, $urandom}, 0, 0);
        for (int i = 0; i < 5; i++) begin
            do_word(0, 1, 1, {$urandom, $urandom}, $urandom_range(0, 2), 0);
        end
        do_word(0, 1, 0, {$urandom, $urandom}, 0, 0);
        do_word(0, 1, 0, {$urandom, $urandom}, 0, 1);
        idle_check(8);

        // ---- randomized regions and traffic ----
        for (int r = 0; r < 4; r++) begin
            logic [ADDR_W-1:0] b;
            b = ADDR_W'($urandom);
            set_region(b, b + ADDR_W'($urandom_range(0, 4)), $urandom_range(0, 3));
            cfg_en = 1'b1;
            for (int w = 0; w < 12; w++) begin
                kind = $urandom_range(0, 3);
                if (kind == 3) kind = 0;
                do_word($urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(0, 3),
                        kind, {$urandom, $urandom}, $urandom_range(0, 3), w == 11);
            end
            idle_check(6);
        end
        check_eq("irq_pulses", irq_cnt, irq_exp);
        check_eq("pass_pulses", pass_cnt, pass_exp);

        // ---- reset mid-read abandons it; the late response is ignored ----
        cfg_en = 1'b1;
        n = 0;
        while (!bus.rd_req_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_case_req", bus.rd_req_valid, 1);
        bus.rd_req_ready = 1'b1;
        @(negedge clk);
        bus.rd_req_ready = 1'b0;
        cfg_en = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("async_rst_ce", ce_count, 0);
        check_eq("async_rst_ue", ue_count, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.rd_rsp_valid      = 1'b1;
        bus.rd_rsp_double_err = 1'b1;
        @(negedge clk);
        bus.rd_rsp_valid      = 1'b0;
        bus.rd_rsp_double_err = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("late_rsp_ue", ue_count, 0);
        check_eq("late_rsp_irq", irq_cnt, irq_exp);
        check_eq("late_rsp_no_req", bus.rd_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
